// File: rtl/sigmoid_share_arb.sv
// Round-robin sharing of one 1-cycle-latency sigmoid unit across NUM_REQ requesters,
// with per-requester response registers. Define SIGARB_STATS_EN for issue/stall counters.
module sigmoid_share_arb #(
  parameter int NUM_REQ = 4,
  parameter int DW      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*DW-1:0] req_x,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [NUM_REQ*DW-1:0] rsp_y,
  input  logic [NUM_REQ-1:0]    rsp_ready,
  output logic [DW-1:0]         sig_x,
  input  logic [DW-1:0]         sig_y,
`ifdef SIGARB_STATS_EN
  output logic [31:0]           stat_issue_cnt,
  output logic [31:0]           stat_stall_cnt,
`endif
  output logic                  busy
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [IW-1:0]      rr_ptr;
  logic [IW-1:0]      infl_id;
  logic               infl_v;
  logic [NUM_REQ-1:0] elig;
  logic               grant_v;
  logic [IW-1:0]      grant_id;

  // A requester is only eligible if its response slot is guaranteed free on completion
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      elig[i] = req_valid[i] && en && (!rsp_valid[i] || rsp_ready[i]) &&
                !(infl_v && (infl_id == IW'(i)));
    end
  end

  always_comb begin
    int idx;
    idx      = 0;
    grant_v  = 1'b0;
    grant_id = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = int'(rr_ptr) + off;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!grant_v && elig[idx]) begin
        grant_v  = 1'b1;
        grant_id = IW'(idx);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    sig_x     = '0;
    if (grant_v) begin
      req_ready[grant_id] = 1'b1;
      sig_x               = req_x[int'(grant_id)*DW +: DW];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr  <= '0;
      infl_v  <= 1'b0;
      infl_id <= '0;
    end else begin
      infl_v <= grant_v;
      if (grant_v) begin
        infl_id <= grant_id;
        rr_ptr  <= (grant_id == IW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
      end
    end
  end

  // Completion takes priority over a same-edge pop of the same slot
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_valid <= '0;
      rsp_y     <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (infl_v && (infl_id == IW'(i))) begin
          rsp_valid[i]         <= 1'b1;
          rsp_y[i*DW +: DW]    <= sig_y;
        end else if (rsp_valid[i] && rsp_ready[i]) begin
          rsp_valid[i]         <= 1'b0;
        end
      end
    end
  end

  assign busy = infl_v | (|rsp_valid);

`ifdef SIGARB_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_issue_cnt <= '0;
      stat_stall_cnt <= '0;
    end else begin
      if (grant_v && (stat_issue_cnt != 32'hFFFF_FFFF))
        stat_issue_cnt <= stat_issue_cnt + 32'd1;
      if ((|req_valid) && !grant_v && (stat_stall_cnt != 32'hFFFF_FFFF))
        stat_stall_cnt <= stat_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sigmoid_share_arb.sv
// Randomized scoreboard bench for sigmoid_share_arb with a registered x+0x0100 sigmoid stub.
module tb_sigmoid_share_arb;
  localparam int N  = 4;
  localparam int DW = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            en = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N*DW-1:0] req_x = '0;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    rsp_valid;
  logic [N*DW-1:0] rsp_y;
  logic [N-1:0]    rsp_ready = '0;
  logic [DW-1:0]   sig_x;
  logic [DW-1:0]   sig_y = '0;
  logic            busy;
`ifdef SIGARB_STATS_EN
  logic [31:0]     stat_issue_cnt, stat_stall_cnt;
`endif

  int tests = 0;
  int fails = 0;

  sigmoid_share_arb #(.NUM_REQ(N), .DW(DW)) dut (
    .clk(clk), .rst(rst), .en(en),
    .req_valid(req_valid), .req_x(req_x), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_y(rsp_y), .rsp_ready(rsp_ready),
    .sig_x(sig_x), .sig_y(sig_y),
`ifdef SIGARB_STATS_EN
    .stat_issue_cnt(stat_issue_cnt), .stat_stall_cnt(stat_stall_cnt),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) sig_y <= sig_x + 16'h0100;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: state as it will be after the next rising edge
  logic [DW-1:0] q[N][$];
  int  m_ptr = 0;
  bit  m_infl_v = 0;
  int  m_infl_id = 0;
  bit  m_full[N];

  task automatic model_reset();
    m_ptr = 0; m_infl_v = 0; m_infl_id = 0;
    for (int i = 0; i < N; i++) begin m_full[i] = 0; q[i].delete(); end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      model_reset();
    end else begin
      bit            elig[N];
      int            g;
      logic [N-1:0]  exp_rdy, exp_rv;
      logic [DW-1:0] exp_sx;
      bit            any_full;
      g = -1; exp_rdy = '0; exp_rv = '0; exp_sx = '0; any_full = 0;
      for (int i = 0; i < N; i++) begin
        elig[i] = req_valid[i] && en && (!m_full[i] || rsp_ready[i]) &&
                  !(m_infl_v && m_infl_id == i);
        exp_rv[i] = m_full[i];
        any_full |= m_full[i];
      end
      for (int off = 0; off < N; off++)
        if (g < 0 && elig[(m_ptr + off) % N]) g = (m_ptr + off) % N;
      if (g >= 0) begin
        exp_rdy[g] = 1'b1;
        exp_sx = req_x[g*DW +: DW];
      end
      chk("req_ready", 64'(req_ready), 64'(exp_rdy));
      chk("sig_x", 64'(sig_x), 64'(exp_sx));
      chk("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
      chk("busy", 64'(busy), 64'(m_infl_v || any_full));
      if (g >= 0) q[g].push_back(exp_sx + 16'h0100);
      for (int i = 0; i < N; i++) begin
        if (m_infl_v && m_infl_id == i) m_full[i] = 1;
        else if (m_full[i] && rsp_ready[i]) m_full[i] = 0;
      end
      m_infl_v = (g >= 0);
      if (g >= 0) begin m_infl_id = g; m_ptr = (g + 1) % N; end
    end
  end

  // Monitor: every accepted response must match the oldest expected value for that requester
  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        if (rsp_valid[i] && rsp_ready[i]) begin
          if (q[i].size() == 0) chk("rsp_unexpected", 64'(i), 64'hFFFF);
          else chk("rsp_y", 64'(rsp_y[i*DW +: DW]), 64'(q[i].pop_front()));
        end
      end
    end
  end

  task automatic run_phase(input logic [N-1:0] mask, input int pv, input int pr,
                           input int pe, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk); #1;
      en = ($urandom_range(99) < pe);
      for (int i = 0; i < N; i++) begin
        req_valid[i]      = mask[i] && ($urandom_range(99) < pv);
        rsp_ready[i]      = ($urandom_range(99) < pr);
        req_x[i*DW +: DW] = DW'($urandom);
      end
    end
  endtask

  initial begin
    model_reset();
    #1;
    chk("reset_rsp_valid", 64'(rsp_valid), 64'h0);
    chk("reset_rsp_y", 64'(rsp_y), 64'h0);
    chk("reset_busy", 64'(busy), 64'h0);
    chk("reset_req_ready", 64'(req_ready), 64'h0);
    #20 rst = 1'b1;

    run_phase(4'b0001, 100, 100, 100, 20);
    run_phase(4'b1111, 100, 100, 100, 200);
    run_phase(4'b0100, 100, 25, 100, 200);
    run_phase(4'b0010, 100, 50, 100, 200);
    run_phase(4'b1111, 70, 50, 60, 800);
    run_phase(4'b1000, 100, 100, 40, 200);
    run_phase(4'b0000, 0, 100, 100, 10);

    // Reset asserted with an operation in flight
    @(posedge clk); #1;
    en = 1'b1; req_valid = 4'b0001; req_x[DW-1:0] = 16'h1234;
    @(posedge clk); #2;
    rst = 1'b0; req_valid = '0;
    #1;
    chk("arst_rsp_valid", 64'(rsp_valid), 64'h0);
    chk("arst_rsp_y", 64'(rsp_y), 64'h0);
    chk("arst_busy", 64'(busy), 64'h0);
    chk("arst_req_ready", 64'(req_ready), 64'h0);
    @(posedge clk); #1 rst = 1'b1;
    run_phase(4'b0000, 0, 100, 100, 5);
    run_phase(4'b1111, 80, 70, 90, 300);
    run_phase(4'b0000, 0, 100, 100, 10);

    @(negedge clk); #1;
    for (int i = 0; i < N; i++) chk("drain_queue_empty", 64'(q[i].size()), 64'h0);
    chk("drain_busy", 64'(busy), 64'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
